atm_dispense_ctrl: RTL and testbench
====================================

// Module: atm_dispense_ctrl
// PURPOSE
//  Transaction controller for the cash path behind the ATM session FSM.
//  - Owns the account balance and the note-cassette count.
//  - Validates withdraw, deposit and balance requests.
//  - Sequences the note-dispenser mechanism one note at a time over a req/ack handshake.
//  - Times out a stuck mechanism.
//  - Returns a status code for each transaction.
// PARAMETERS
//  AMT_W       16    width of amounts and the balance
//  CNT_W       8     width of the note counters
//  NOTE_VAL    100   value of one note (constant; amounts must be multiples of it)
//  INIT_BAL    5000  balance loaded at reset
//  INIT_NOTES  20    cassette count loaded at reset
//  TIMEOUT     64    max cycles note_req may wait for note_ack
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      asynchronous, active-low reset
//  txn_req       in   1      transaction request
//  txn_op        in   2      00 withdraw, 01 deposit, 10 balance, 11 illegal
//  txn_amount    in   AMT_W  transaction amount
//  txn_ready     out  1      controller can accept a transaction
//  txn_done      out  1      one-cycle completion pulse
//  txn_status    out  3      0 OK, 1 BAD_AMT, 2 NO_FUNDS, 3 NO_NOTES, 4 OVERFLOW, 5 FAULT, 6 BAD_OP
//  balance_out   out  AMT_W  current balance
//  notes_left    out  CNT_W  notes remaining in the cassette
//  note_req      out  1      dispense one note
//  note_ack      in   1      mechanism has dispensed the note
//  refill        in   1      load the cassette
//  refill_count  in   CNT_W  new cassette count
//  fault         out  1      sticky mechanism fault
// BEHAVIOUR
//  Reset (rst=0, asynchronous): FSM goes to IDLE.
//  - Reset values: balance=INIT_BAL, notes_left=INIT_NOTES; txn_done, note_req and fault =0; txn_status=0.
//  - This applies mid-dispense too: note_req drops at once and the partial transaction is discarded.
//  FSM states: IDLE, CHECK, DISP, GAP, DONE.
//  - IDLE: txn_ready=1. txn_req=1 accepts the transaction; op and amount are registered; go to CHECK.
//  - CHECK: evaluate, in priority order:
//    - op==11 -> BAD_OP.
//    - Withdraw: amount==0 or amount%NOTE_VAL!=0 -> BAD_AMT; else fault -> FAULT.
//      Then amount>balance -> NO_FUNDS; then amount/NOTE_VAL>notes_left -> NO_NOTES.
//      Otherwise remaining=amount/NOTE_VAL and go to DISP.
//    - Deposit: amount==0 or amount%NOTE_VAL!=0 -> BAD_AMT; balance+amount>2^AMT_W-1 -> OVERFLOW.
//      Otherwise balance+=amount and status OK.
//    - Balance: OK, no state change.
//    - Every path except a valid withdraw goes to DONE.
//  - DISP: note_req=1 and the timeout counter increments.
//    - note_ack=1: balance-=NOTE_VAL, notes_left-=1, remaining-=1, counter clears.
//      Go to DONE with status OK if remaining reaches 0, else to GAP.
//    - Counter reaches TIMEOUT-1 without ack: fault=1, status FAULT, go to DONE.
//      Notes already dispensed stay debited.
//  - GAP: note_req=0 for exactly one cycle, then DISP.
//  - DONE: txn_done=1 for one cycle, then IDLE. txn_status holds until the next accept.
//  Latency from the accept edge:
//  - Balance, deposit and rejected transactions: txn_done is high 2 cycles later.
//  - Withdraw of k notes with immediate acks: txn_done at 2k+1 cycles.
//  - note_ack is ignored outside DISP.
//  Refill: sampled only in IDLE; sets notes_left=refill_count and clears fault.
//  - If refill and txn_req arrive in the same cycle, both are taken; CHECK sees the refilled count.
//  - Refill outside IDLE is ignored.
//  Balance never wraps. A withdraw can never underflow, because it is checked before any note is dispensed.
// TESTING
//  1. Reset, balance op -> txn_done 2 cycles after accept; status 0; balance_out=5000, notes_left=20.
//  2. Withdraw 300, ack one cycle after each note_req -> 3 note_req pulses separated by GAP cycles.
//     Then balance=4700, notes=17, status 0.
//  3. Withdraw 250 -> BAD_AMT. Withdraw 6000 -> NO_FUNDS. refill 2 then withdraw 300 -> NO_NOTES.
//     In all three: no note_req and no state change.
//  4. Deposit 65500 on balance 4700 -> OVERFLOW, balance unchanged.
//     Deposit 500 -> balance 5200, status OK.
//  5. Withdraw 200, ack the first note only -> FAULT after 64 cycles; balance -100; fault=1.
//     Next withdraw -> FAULT. refill 20 -> fault=0.
//  6. Drive rst low mid-DISP -> note_req drops asynchronously; balance=5000, notes=20, FSM in IDLE.

Source files
------------

// File: rtl/atm_dispense_ctrl.sv
// ATM cash-path transaction controller: owns balance and cassette count,
// validates withdraw/deposit/balance requests and drives the note dispenser
// one note at a time over a req/ack handshake with a stuck-mechanism timeout.
module atm_dispense_ctrl #(
    parameter int unsigned AMT_W      = 16,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned NOTE_VAL   = 100,
    parameter int unsigned INIT_BAL   = 5000,
    parameter int unsigned INIT_NOTES = 20,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             txn_req,
    input  logic [1:0]       txn_op,
    input  logic [AMT_W-1:0] txn_amount,
    output logic             txn_ready,
    output logic             txn_done,
    output logic [2:0]       txn_status,
    output logic [AMT_W-1:0] balance_out,
    output logic [CNT_W-1:0] notes_left,
    output logic             note_req,
    input  logic             note_ack,
    input  logic             refill,
    input  logic [CNT_W-1:0] refill_count,
    output logic             fault
);

    localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [AMT_W-1:0] NOTE_AMT = AMT_W'(NOTE_VAL);

    localparam logic [2:0] ST_OK       = 3'd0;
    localparam logic [2:0] ST_BAD_AMT  = 3'd1;
    localparam logic [2:0] ST_NO_FUNDS = 3'd2;
    localparam logic [2:0] ST_NO_NOTES = 3'd3;
    localparam logic [2:0] ST_OVERFLOW = 3'd4;
    localparam logic [2:0] ST_FAULT    = 3'd5;
    localparam logic [2:0] ST_BAD_OP   = 3'd6;

    typedef enum logic [2:0] {IDLE, CHECK, DISP, GAP, DONE} state_t;

    state_t             state_q;
    logic [1:0]         op_q;
    logic [AMT_W-1:0]   amt_q;
    logic [AMT_W-1:0]   bal_q;
    logic [CNT_W-1:0]   notes_q;
    logic [CNT_W-1:0]   rem_q;
    logic [TMR_W-1:0]   tmr_q;
    logic               ready_q;
    logic               done_q;
    logic [2:0]         status_q;
    logic               note_req_q;
    logic               fault_q;

    logic               amt_bad_c;
    logic [AMT_W-1:0]   notes_need_c;
    logic               no_notes_c;
    logic [AMT_W:0]     dep_sum_c;

    // Validation terms for the registered transaction, used only in CHECK
    always_comb begin
        amt_bad_c    = (amt_q == '0) || ((amt_q % NOTE_AMT) != '0);
        notes_need_c = amt_q / NOTE_AMT;
        no_notes_c   = notes_need_c > AMT_W'(notes_q);
        dep_sum_c    = {1'b0, bal_q} + {1'b0, amt_q};
    end

    // Transaction FSM with registered handshake, status and account state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            op_q       <= 2'b00;
            amt_q      <= '0;
            bal_q      <= AMT_W'(INIT_BAL);
            notes_q    <= CNT_W'(INIT_NOTES);
            rem_q      <= '0;
            tmr_q      <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            status_q   <= ST_OK;
            note_req_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (refill) begin
                        notes_q <= refill_count;
                        fault_q <= 1'b0;
                    end
                    if (txn_req) begin
                        op_q    <= txn_op;
                        amt_q   <= txn_amount;
                        ready_q <= 1'b0;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    state_q <= DONE;
                    case (op_q)
                        2'b00: begin
                            if (amt_bad_c)          status_q <= ST_BAD_AMT;
                            else if (fault_q)       status_q <= ST_FAULT;
                            else if (amt_q > bal_q) status_q <= ST_NO_FUNDS;
                            else if (no_notes_c)    status_q <= ST_NO_NOTES;
                            else begin
                                rem_q      <= CNT_W'(notes_need_c);
                                tmr_q      <= '0;
                                note_req_q <= 1'b1;
                                state_q    <= DISP;
                            end
                        end
                        2'b01: begin
                            if (amt_bad_c)              status_q <= ST_BAD_AMT;
                            else if (dep_sum_c[AMT_W])  status_q <= ST_OVERFLOW;
                            else begin
                                bal_q    <= dep_sum_c[AMT_W-1:0];
                                status_q <= ST_OK;
                            end
                        end
                        2'b10:   status_q <= ST_OK;
                        default: status_q <= ST_BAD_OP;
                    endcase
                end
                DISP: begin
                    if (note_ack) begin
                        bal_q      <= bal_q - NOTE_AMT;
                        notes_q    <= notes_q - CNT_W'(1);
                        rem_q      <= rem_q - CNT_W'(1);
                        tmr_q      <= '0;
                        note_req_q <= 1'b0;
                        if (rem_q == CNT_W'(1)) begin
                            status_q <= ST_OK;
                            state_q  <= DONE;
                        end else begin
                            state_q  <= GAP;
                        end
                    end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                        fault_q    <= 1'b1;
                        status_q   <= ST_FAULT;
                        note_req_q <= 1'b0;
                        state_q    <= DONE;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                GAP: begin
                    note_req_q <= 1'b1;
                    state_q    <= DISP;
                end
                DONE: begin
                    done_q  <= 1'b1;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    note_req_q <= 1'b0;
                    ready_q    <= 1'b1;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign txn_ready   = ready_q;
    assign txn_done    = done_q;
    assign txn_status  = status_q;
    assign balance_out = bal_q;
    assign notes_left  = notes_q;
    assign note_req    = note_req_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_atm_dispense_ctrl.sv
// Directed self-checking bench for atm_dispense_ctrl.
module tb_atm_dispense_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        txn_req;
    logic [1:0]  txn_op;
    logic [15:0] txn_amount;
    logic        txn_ready;
    logic        txn_done;
    logic [2:0]  txn_status;
    logic [15:0] balance_out;
    logic [7:0]  notes_left;
    logic        note_req;
    logic        note_ack;
    logic        refill;
    logic [7:0]  refill_count;
    logic        fault;

    int total = 0;
    int bad   = 0;
    int lat;
    int pul;

    always #5 clk = ~clk;

    atm_dispense_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .txn_req      (txn_req),
        .txn_op       (txn_op),
        .txn_amount   (txn_amount),
        .txn_ready    (txn_ready),
        .txn_done     (txn_done),
        .txn_status   (txn_status),
        .balance_out  (balance_out),
        .notes_left   (notes_left),
        .note_req     (note_req),
        .note_ack     (note_ack),
        .refill       (refill),
        .refill_count (refill_count),
        .fault        (fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (txn_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check("ready_wait", {31'd0, txn_ready}, 32'd1);
    endtask

    task automatic do_refill(input logic [7:0] cnt);
        wait_ready();
        refill       = 1'b1;
        refill_count = cnt;
        step();
        refill       = 1'b0;
    endtask

    // Issue one transaction; mechanism acks the first 'budget' notes one cycle after each req.
    task automatic run_txn(input logic [1:0] op, input logic [15:0] amt, input int budget,
                           input logic rf, input logic [7:0] rf_cnt,
                           output int latency, output int pulses);
        int   c;
        int   b;
        logic prev;
        wait_ready();
        txn_op       = op;
        txn_amount   = amt;
        txn_req      = 1'b1;
        refill       = rf;
        refill_count = rf_cnt;
        step();
        txn_req = 1'b0;
        refill  = 1'b0;
        c = 0; b = budget; prev = 1'b0; pulses = 0;
        while (c < 300) begin
            step();
            c++;
            if (note_req === 1'b1 && prev !== 1'b1) pulses++;
            prev = note_req;
            if (txn_done === 1'b1) break;
            note_ack = (note_req === 1'b1) && (b > 0);
            if (note_ack) b--;
        end
        note_ack = 1'b0;
        latency  = c;
    endtask

    initial begin
        rst = 1'b0; txn_req = 1'b0; txn_op = 2'b00; txn_amount = 16'd0;
        note_ack = 1'b0; refill = 1'b0; refill_count = 8'd0;
        #12;
        check("rst_ready",  {31'd0, txn_ready}, 32'd1);
        check("rst_done",   {31'd0, txn_done},  32'd0);
        check("rst_notereq",{31'd0, note_req},  32'd0);
        check("rst_fault",  {31'd0, fault},     32'd0);
        check("rst_status", {29'd0, txn_status},32'd0);
        check("rst_bal",    {16'd0, balance_out}, 32'd5000);
        check("rst_notes",  {24'd0, notes_left},  32'd20);
        step();
        rst = 1'b1;

        // balance query
        run_txn(2'b10, 16'd0, 0, 1'b0, 8'd0, lat, pul);
        check("bal_lat",    lat, 2);
        check("bal_status", {29'd0, txn_status}, 0);
        check("bal_bal",    {16'd0, balance_out}, 5000);
        check("bal_notes",  {24'd0, notes_left}, 20);

        // withdraw 300 with immediate acks
        run_txn(2'b00, 16'd300, 3, 1'b0, 8'd0, lat, pul);
        check("wd300_lat",    lat, 7);
        check("wd300_pulses", pul, 3);
        check("wd300_status", {29'd0, txn_status}, 0);
        check("wd300_bal",    {16'd0, balance_out}, 4700);
        check("wd300_notes",  {24'd0, notes_left}, 17);

        // rejected withdrawals
        run_txn(2'b00, 16'd250, 3, 1'b0, 8'd0, lat, pul);
        check("wd250_status", {29'd0, txn_status}, 1);
        check("wd250_lat",    lat, 2);
        check("wd250_pulses", pul, 0);
        check("wd250_bal",    {16'd0, balance_out}, 4700);
        run_txn(2'b00, 16'd6000, 3, 1'b0, 8'd0, lat, pul);
        check("wd6000_status", {29'd0, txn_status}, 2);
        check("wd6000_pulses", pul, 0);
        check("wd6000_bal",    {16'd0, balance_out}, 4700);
        do_refill(8'd2);
        check("refill2_notes", {24'd0, notes_left}, 2);
        run_txn(2'b00, 16'd300, 3, 1'b0, 8'd0, lat, pul);
        check("nonotes_status", {29'd0, txn_status}, 3);
        check("nonotes_pulses", pul, 0);
        check("nonotes_notes",  {24'd0, notes_left}, 2);
        check("nonotes_bal",    {16'd0, balance_out}, 4700);

        // deposits and illegal op
        run_txn(2'b01, 16'd65500, 0, 1'b0, 8'd0, lat, pul);
        check("ovf_status", {29'd0, txn_status}, 4);
        check("ovf_bal",    {16'd0, balance_out}, 4700);
        run_txn(2'b01, 16'd500, 0, 1'b0, 8'd0, lat, pul);
        check("dep_status", {29'd0, txn_status}, 0);
        check("dep_lat",    lat, 2);
        check("dep_bal",    {16'd0, balance_out}, 5200);
        run_txn(2'b01, 16'd0, 0, 1'b0, 8'd0, lat, pul);
        check("dep0_status", {29'd0, txn_status}, 1);
        run_txn(2'b11, 16'd100, 0, 1'b0, 8'd0, lat, pul);
        check("badop_status", {29'd0, txn_status}, 6);
        check("badop_lat",    lat, 2);

        // mechanism stalls after the first note
        run_txn(2'b00, 16'd200, 1, 1'b0, 8'd0, lat, pul);
        check("to_status", {29'd0, txn_status}, 5);
        check("to_lat",    lat, 68);
        check("to_pulses", pul, 2);
        check("to_fault",  {31'd0, fault}, 1);
        check("to_bal",    {16'd0, balance_out}, 5100);
        check("to_notes",  {24'd0, notes_left}, 1);
        run_txn(2'b00, 16'd100, 1, 1'b0, 8'd0, lat, pul);
        check("flt_status", {29'd0, txn_status}, 5);
        check("flt_pulses", pul, 0);
        check("flt_bal",    {16'd0, balance_out}, 5100);
        do_refill(8'd20);
        check("refill_fault", {31'd0, fault}, 0);
        check("refill_notes", {24'd0, notes_left}, 20);

        // refill and request in the same cycle: check sees the new count
        run_txn(2'b00, 16'd300, 3, 1'b1, 8'd3, lat, pul);
        check("rfreq_status", {29'd0, txn_status}, 0);
        check("rfreq_notes",  {24'd0, notes_left}, 0);
        check("rfreq_bal",    {16'd0, balance_out}, 4800);
        run_txn(2'b00, 16'd100, 1, 1'b0, 8'd0, lat, pul);
        check("empty_status", {29'd0, txn_status}, 3);
        do_refill(8'd20);

        // asynchronous reset mid-dispense
        wait_ready();
        txn_op = 2'b00; txn_amount = 16'd500; txn_req = 1'b1;
        step();
        txn_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (note_req === 1'b1) break;
            step();
        end
        check("mid_notereq", {31'd0, note_req}, 1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_notereq", {31'd0, note_req}, 0);
        check("arst_bal",     {16'd0, balance_out}, 5000);
        check("arst_notes",   {24'd0, notes_left}, 20);
        check("arst_ready",   {31'd0, txn_ready}, 1);
        check("arst_done",    {31'd0, txn_done}, 0);
        step();
        rst = 1'b1;
        run_txn(2'b10, 16'd0, 0, 1'b0, 8'd0, lat, pul);
        check("post_lat",    lat, 2);
        check("post_status", {29'd0, txn_status}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
